tpu_tile_sequencer: RTL and testbench
=====================================

Name: tpu_tile_sequencer

Overview:
Top-level sequencer for the TPU datapath. It walks layers, output channels and tiles, and for each tile does the following:
- pulses the sliding-window start;
- issues K read beats to the active tensor RAM pointer and the weight ROM pointer;
- generates read-latency-aligned valid_in strobes;
- signals tile done to the STA controller and waits for STA idle.
It also owns layer_idx, which selects the tensor RAM ping-pong bank.

Parameters:
NUM_LAYERS, 6, number of model layers sequenced per run
MAX_NUM_CH, 64, max output channels (filters) per layer
MAX_TILES, 256, max tiles per output channel
MAX_K, 64, max read beats per tile
READ_LAT, 1, cycles from read issue to RAM/ROM data valid (1..3)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  pulse: begin full-model run (ignored while busy)
stall  in  1  freeze read issue and all counters
sta_idle  in  1  STA complex idle
cfg_num_filters  in  $clog2(MAX_NUM_CH+1)  filters of layer layer_idx (combinational lookup, sampled in S_CFG)
cfg_num_tiles  in  $clog2(MAX_TILES+1)  tiles per channel, sampled in S_CFG
cfg_k_beats  in  $clog2(MAX_K+1)  read beats per tile, sampled in S_CFG
layer_idx  out  $clog2(NUM_LAYERS)  current layer; bit0 = read bank (0: read A/write B... per datapath)
chnnl_idx  out  $clog2(MAX_NUM_CH)  current output channel
tile_idx  out  $clog2(MAX_TILES)  current tile
reset_sta  out  1  one-cycle pulse at each layer start
start_window  out  1  one-cycle pulse at each tile start
read_inputs  out  1  activation read issue
read_weights  out  1  weight read issue
incr_ptr_act  out  1  increment active-bank pixel pointer
incr_ptr_wgt  out  1  increment weight pointer
valid_in_act  out  1  activation data valid to sliding window
valid_in_wgt  out  1  weight data valid to sliding window
tile_done  out  1  one-cycle pulse to STA "done"
busy  out  1  high from start accept until all_done
all_done  out  1  one-cycle pulse after last tile of last layer

Behaviour:
- Reset: state S_IDLE. All outputs 0. Indices 0. Valid pipe cleared. Reset mid-run aborts immediately.
- S_IDLE: on start, set busy=1 and layer_idx=0, then go to S_CFG.
- S_CFG (1 cycle):
  - Latch cfg_*; any zero value is clamped to 1.
  - Pulse reset_sta; set chnnl_idx=0 and tile_idx=0.
  - Go to S_TSTART.
- S_TSTART (1 cycle): pulse start_window, load beat counter = k_beats, go to S_FETCH.
- S_FETCH:
  - Each non-stalled cycle drives read_inputs = read_weights = incr_ptr_act = incr_ptr_wgt = 1 and decrements the beat counter.
  - When the last beat issues, go to S_DRAIN.
  - With stall=1, all four are 0 and the counter holds.
- Valid pipe: a READ_LAT-deep shift register fed by the issue strobe. valid_in_act = valid_in_wgt = pipe output. The pipe keeps shifting during stall, so issued beats still emerge. Exactly k_beats valid pulses occur per tile.
- S_DRAIN: wait until the pipe is empty, pulse tile_done, go to S_WAIT.
- S_WAIT:
  - Advance to S_NEXT when sta_idle=1 and stall=0.
  - sta_idle is ignored in the cycle tile_done is high.
- S_NEXT (1 cycle), nested wrap:
  - tile++.
  - When tile wraps at num_tiles-1, channel++.
  - When channel wraps at num_filters-1, layer++ and go to S_CFG.
  - When layer is NUM_LAYERS-1 and both inner counters wrap, go to S_FINISH.
  - Otherwise go to S_TSTART.
- S_FINISH: pulse all_done, clear busy, return to S_IDLE. layer_idx holds its final value until the next start.
- start while busy: ignored. Stall outside S_FETCH/S_WAIT: no effect (single-cycle states proceed).
- Per-tile latency with no stall: 1 + k + READ_LAT + 1 + (wait) + 1 cycles.

Optional Feature:
TPU_SEQ_PERF_EN:
- Defined: adds outputs perf_busy_cycles[31:0] and perf_stall_cycles[31:0].
  - perf_busy_cycles counts cycles with busy=1.
  - perf_stall_cycles counts cycles with busy=1 and stall=1.
  - Both saturate at 2^32-1, clear on start accept, and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- NUM_LAYERS=2, cfg filters=1, tiles=1, k=4, sta_idle=1, READ_LAT=1 -> 4 consecutive read/incr cycles per tile; valid pulses one cycle later; 2 reset_sta pulses; all_done after 2 tiles; layer_idx 0 then 1.
- filters=2, tiles=3, k=2 -> tile_idx sequence 0,1,2,0,1,2 with chnnl_idx 0,0,0,1,1,1; 6 start_window and 6 tile_done pulses per layer.
- stall=1 for 3 cycles mid-FETCH with k=4 -> exactly 4 issues and 4 valid pulses; fetch phase stretched by 3 cycles.
- sta_idle held 0 for 10 cycles after tile_done -> no start_window until the cycle after sta_idle rises.
- cfg_k_beats=0 -> behaves as k=1; start pulsed while busy -> ignored, run count unchanged.
- reset asserted in S_FETCH -> all outputs 0 asynchronously, busy=0, the next start restarts at layer 0.

Source files
------------

// File: rtl/tpu_tile_sequencer.sv
// ----------------------------------------------------------------------------
// tpu_tile_sequencer
//
// Top-level sequencer for the TPU datapath. For every layer, output channel
// and tile it pulses the sliding-window start, issues K read beats to the
// tensor RAM / weight ROM pointers, delays the issue strobe by READ_LAT cycles
// to form valid_in, reports tile_done to the STA controller and waits for the
// STA complex to go idle. layer_idx bit0 selects the tensor RAM ping-pong bank.
//
// Optional build macro: TPU_SEQ_PERF_EN adds perf_busy_cycles and
// perf_stall_cycles (saturating 32-bit counters, cleared on start accept).
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   start                 pulse: begin a full-model run (ignored while busy)
//   stall                 freezes read issue and the beat/tile counters
//   sta_idle              STA complex idle
//   cfg_num_filters       filters of layer layer_idx, sampled in S_CFG
//   cfg_num_tiles         tiles per channel, sampled in S_CFG
//   cfg_k_beats           read beats per tile, sampled in S_CFG
//   layer_idx/chnnl_idx/tile_idx   current position in the walk
//   reset_sta             one-cycle pulse at each layer start
//   start_window          one-cycle pulse at each tile start
//   read_inputs/read_weights/incr_ptr_act/incr_ptr_wgt   read issue strobes
//   valid_in_act/valid_in_wgt      read-latency-aligned data valid
//   tile_done             one-cycle pulse to STA "done"
//   busy                  high from start accept until all_done
//   all_done              one-cycle pulse after the last tile of the last layer
// ----------------------------------------------------------------------------
module tpu_tile_sequencer #(
  parameter int NUM_LAYERS = 6,
  parameter int MAX_NUM_CH = 64,
  parameter int MAX_TILES  = 256,
  parameter int MAX_K      = 64,
  parameter int READ_LAT   = 1,
  localparam int LAYER_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int CH_W      = (MAX_NUM_CH > 1) ? $clog2(MAX_NUM_CH) : 1,
  localparam int TILE_W    = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1,
  localparam int FILT_W    = $clog2(MAX_NUM_CH + 1),
  localparam int NT_W      = $clog2(MAX_TILES + 1),
  localparam int K_W       = $clog2(MAX_K + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               sta_idle,
  input  logic [FILT_W-1:0]  cfg_num_filters,
  input  logic [NT_W-1:0]    cfg_num_tiles,
  input  logic [K_W-1:0]     cfg_k_beats,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [CH_W-1:0]    chnnl_idx,
  output logic [TILE_W-1:0]  tile_idx,
  output logic               reset_sta,
  output logic               start_window,
  output logic               read_inputs,
  output logic               read_weights,
  output logic               incr_ptr_act,
  output logic               incr_ptr_wgt,
  output logic               valid_in_act,
  output logic               valid_in_wgt,
  output logic               tile_done,
  output logic               busy,
`ifdef TPU_SEQ_PERF_EN
  output logic [31:0]        perf_busy_cycles,
  output logic [31:0]        perf_stall_cycles,
`endif
  output logic               all_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_TSTART, S_FETCH, S_DRAIN, S_WAIT, S_NEXT, S_FINISH
  } state_t;

  state_t              state, state_d;
  logic [FILT_W-1:0]   num_filters;
  logic [NT_W-1:0]     num_tiles;
  logic [K_W-1:0]      k_beats;
  logic [K_W-1:0]      beat_cnt;
  logic [READ_LAT-1:0] valid_pipe;
  logic                issue;
  logic                last_tile, last_ch, last_layer;

  assign last_tile  = (NT_W'(tile_idx) == num_tiles - NT_W'(1));
  assign last_ch    = (FILT_W'(chnnl_idx) == num_filters - FILT_W'(1));
  assign last_layer = (layer_idx == LAYER_W'(NUM_LAYERS - 1));

  // Next-state and strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d      = state;
    issue        = 1'b0;
    reset_sta    = 1'b0;
    start_window = 1'b0;
    tile_done    = 1'b0;
    all_done     = 1'b0;
    case (state)
      S_IDLE:   if (start) state_d = S_CFG;
      S_CFG: begin
        reset_sta = 1'b1;
        state_d   = S_TSTART;
      end
      S_TSTART: begin
        start_window = 1'b1;
        state_d      = S_FETCH;
      end
      S_FETCH: begin
        if (!stall) begin
          issue = 1'b1;
          if (beat_cnt == K_W'(1)) state_d = S_DRAIN;
        end
      end
      // Beats issued in the last fetch cycles are still in flight; report
      // the tile only once every one of them has emerged as valid_in.
      S_DRAIN: begin
        if (valid_pipe == '0) begin
          tile_done = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT:   if (sta_idle && !stall) state_d = S_NEXT;
      S_NEXT: begin
        if (last_tile && last_ch) state_d = last_layer ? S_FINISH : S_CFG;
        else                      state_d = S_TSTART;
      end
      S_FINISH: begin
        all_done = 1'b1;
        state_d  = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  assign read_inputs  = issue;
  assign read_weights = issue;
  assign incr_ptr_act = issue;
  assign incr_ptr_wgt = issue;
  assign valid_in_act = valid_pipe[READ_LAT-1];
  assign valid_in_wgt = valid_pipe[READ_LAT-1];
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      layer_idx   <= '0;
      chnnl_idx   <= '0;
      tile_idx    <= '0;
      num_filters <= FILT_W'(1);
      num_tiles   <= NT_W'(1);
      k_beats     <= K_W'(1);
      beat_cnt    <= '0;
      valid_pipe  <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state <= state_d;

      // The valid pipe shifts every cycle, stall or not, so beats already
      // issued still reach the sliding window.
      valid_pipe[0] <= issue;
      for (int i = 1; i < READ_LAT; i++) valid_pipe[i] <= valid_pipe[i-1];

      case (state)
        S_IDLE: if (start) layer_idx <= '0;
        S_CFG: begin
          num_filters <= (cfg_num_filters == '0) ? FILT_W'(1) : cfg_num_filters;
          num_tiles   <= (cfg_num_tiles   == '0) ? NT_W'(1)   : cfg_num_tiles;
          k_beats     <= (cfg_k_beats     == '0) ? K_W'(1)    : cfg_k_beats;
          chnnl_idx   <= '0;
          tile_idx    <= '0;
        end
        S_TSTART: beat_cnt <= k_beats;
        S_FETCH:  if (!stall) beat_cnt <= beat_cnt - K_W'(1);
        S_NEXT: begin
          if (last_tile) begin
            tile_idx <= '0;
            if (last_ch) begin
              chnnl_idx <= '0;
              // On the final layer layer_idx holds so it stays visible after
              // the run until the next start.
              if (!last_layer) layer_idx <= layer_idx + LAYER_W'(1);
            end else begin
              chnnl_idx <= chnnl_idx + CH_W'(1);
            end
          end else begin
            tile_idx <= tile_idx + TILE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TPU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (state == S_IDLE && start) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (busy && stall && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// ----------------------------------------------------------------------------
// tb_tpu_tile_sequencer
//
// Directed bench for tpu_tile_sequencer with NUM_LAYERS=2, READ_LAT=1.
// A negedge monitor logs strobe activity with cycle stamps; each scenario
// task drives stimulus and compares the logs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_tpu_tile_sequencer;

  localparam int NUM_LAYERS = 2;
  localparam int MAX_NUM_CH = 64;
  localparam int MAX_TILES  = 256;
  localparam int MAX_K      = 64;
  localparam int READ_LAT   = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       sta_idle = 1'b1;
  logic [6:0] cfg_num_filters = 7'd1;
  logic [8:0] cfg_num_tiles = 9'd1;
  logic [6:0] cfg_k_beats = 7'd1;
  logic       layer_idx;
  logic [5:0] chnnl_idx;
  logic [7:0] tile_idx;
  logic       reset_sta, start_window, read_inputs, read_weights;
  logic       incr_ptr_act, incr_ptr_wgt, valid_in_act, valid_in_wgt;
  logic       tile_done, busy, all_done;
`ifdef TPU_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

  tpu_tile_sequencer #(
    .NUM_LAYERS(NUM_LAYERS), .MAX_NUM_CH(MAX_NUM_CH), .MAX_TILES(MAX_TILES),
    .MAX_K(MAX_K), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .sta_idle(sta_idle),
    .cfg_num_filters(cfg_num_filters), .cfg_num_tiles(cfg_num_tiles),
    .cfg_k_beats(cfg_k_beats), .layer_idx(layer_idx), .chnnl_idx(chnnl_idx),
    .tile_idx(tile_idx), .reset_sta(reset_sta), .start_window(start_window),
    .read_inputs(read_inputs), .read_weights(read_weights),
    .incr_ptr_act(incr_ptr_act), .incr_ptr_wgt(incr_ptr_wgt),
    .valid_in_act(valid_in_act), .valid_in_wgt(valid_in_wgt),
    .tile_done(tile_done), .busy(busy),
`ifdef TPU_SEQ_PERF_EN
    .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles),
`endif
    .all_done(all_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // Activity logs, filled by the monitor and cleared by clear_logs.
  int   rsta_layer_q[$];
  int   sw_cyc_q[$];
  int   sw_tile_q[$];
  int   sw_ch_q[$];
  int   sw_layer_q[$];
  int   iss_q[$];
  int   val_q[$];
  int   n_td = 0;
  int   n_ad = 0;
  int   n_incoh = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (reset_sta) rsta_layer_q.push_back(int'(layer_idx));
      if (start_window) begin
        sw_cyc_q.push_back(cyc);
        sw_tile_q.push_back(int'(tile_idx));
        sw_ch_q.push_back(int'(chnnl_idx));
        sw_layer_q.push_back(int'(layer_idx));
      end
      if (read_inputs) iss_q.push_back(cyc);
      if (valid_in_act) val_q.push_back(cyc);
      if (tile_done) n_td++;
      if (all_done) n_ad++;
      if ({read_weights, incr_ptr_act, incr_ptr_wgt} != {3{read_inputs}}) n_incoh++;
      if (valid_in_wgt != valid_in_act) n_incoh++;
      if (read_inputs && stall) n_incoh++;
    end
  end

  task automatic clear_logs();
    rsta_layer_q.delete(); sw_cyc_q.delete(); sw_tile_q.delete();
    sw_ch_q.delete(); sw_layer_q.delete(); iss_q.delete(); val_q.delete();
    n_td = 0; n_ad = 0; n_incoh = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for all_done; an expired budget counts as a failed check.
  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (all_done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: all_done not seen within %0d cycles", name, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({reset_sta, start_window, read_inputs, read_weights, incr_ptr_act,
         incr_ptr_wgt, valid_in_act, valid_in_wgt, tile_done, busy, all_done} !== 11'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b want 0", {reset_sta, start_window, read_inputs,
               read_weights, incr_ptr_act, incr_ptr_wgt, valid_in_act, valid_in_wgt,
               tile_done, busy, all_done});
    end
    checks++;
    if ({layer_idx, chnnl_idx, tile_idx} !== 15'b0) begin
      failures++;
      $display("FAIL reset_indices: got %h want 0", {layer_idx, chnnl_idx, tile_idx});
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int bad = 0;
    cfg_num_filters = 7'd1; cfg_num_tiles = 9'd1; cfg_k_beats = 7'd4;
    sta_idle = 1'b1; stall = 1'b0;
    clear_logs();
    pulse_start();
    wait_done("basic_done", 200);
    checks++;
    if (iss_q.size() != 8 || val_q.size() != 8) begin
      failures++;
      $display("FAIL basic_counts: issues=%0d valids=%0d want 8/8", iss_q.size(), val_q.size());
    end
    checks++;
    if (rsta_layer_q.size() != 2 || sw_cyc_q.size() != 2 || n_td != 2 || n_ad != 1) begin
      failures++;
      $display("FAIL basic_pulses: reset_sta=%0d start_window=%0d tile_done=%0d all_done=%0d want 2/2/2/1",
               rsta_layer_q.size(), sw_cyc_q.size(), n_td, n_ad);
    end else begin
      checks++;
      if (rsta_layer_q[0] != 0 || rsta_layer_q[1] != 1) begin
        failures++;
        $display("FAIL basic_layers: got %0d,%0d want 0,1", rsta_layer_q[0], rsta_layer_q[1]);
      end
      // TSTART + 4 fetch + 2 drain + 1 wait + 1 next + 1 cfg between tile starts.
      checks++;
      if (sw_cyc_q[1] - sw_cyc_q[0] != 10) begin
        failures++;
        $display("FAIL basic_tile_period: got %0d want 10", sw_cyc_q[1] - sw_cyc_q[0]);
      end
    end
    if (iss_q.size() == 8 && val_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        if (val_q[i] != iss_q[i] + 1) bad++;
        if (i % 4 != 0 && iss_q[i] != iss_q[i-1] + 1) bad++;
        if (i % 4 == 0 && iss_q[i] != sw_cyc_q[i/4] + 1) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL basic_timing: %0d misaligned issue/valid cycles want 0", bad);
      end
    end
    checks++;
    if (busy !== 1'b0 || layer_idx !== 1'b1 || n_incoh != 0) begin
      failures++;
      $display("FAIL basic_end: busy=%b layer_idx=%b incoherent=%0d want 0,1,0",
               busy, layer_idx, n_incoh);
    end
  endtask

  task automatic test_nested();
    int bad = 0;
    cfg_num_filters = 7'd2; cfg_num_tiles = 9'd3; cfg_k_beats = 7'd2;
    clear_logs();
    pulse_start();
    wait_done("nested_done", 800);
    checks++;
    if (sw_cyc_q.size() != 12 || n_td != 12 || iss_q.size() != 24 || val_q.size() != 24) begin
      failures++;
      $display("FAIL nested_counts: start_window=%0d tile_done=%0d issues=%0d valids=%0d want 12/12/24/24",
               sw_cyc_q.size(), n_td, iss_q.size(), val_q.size());
    end else begin
      for (int i = 0; i < 12; i++)
        if (sw_tile_q[i] != i % 3 || sw_ch_q[i] != (i / 3) % 2 || sw_layer_q[i] != i / 6) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL nested_sequence: %0d wrong tile/channel/layer entries want 0", bad);
      end
    end
    checks++;
    if (rsta_layer_q.size() != 2 || n_ad != 1) begin
      failures++;
      $display("FAIL nested_pulses: reset_sta=%0d all_done=%0d want 2/1", rsta_layer_q.size(), n_ad);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    bit seen = 1'b0;
    cfg_num_filters = 7'd1; cfg_num_tiles = 9'd1; cfg_k_beats = 7'd4;
    clear_logs();
    pulse_start();
    for (int i = 0; i < 20 && !seen; i++) begin
      if (start_window) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stall_sync: start_window not seen within 20 cycles");
    end
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    stall = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    stall = 1'b0;
    wait_done("stall_done", 200);
    checks++;
    if (iss_q.size() != 8 || val_q.size() != 8) begin
      failures++;
      $display("FAIL stall_counts: issues=%0d valids=%0d want 8/8", iss_q.size(), val_q.size());
    end else begin
      for (int i = 0; i < 8; i++) if (val_q[i] != iss_q[i] + 1) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL stall_valid_align: %0d misaligned valids want 0", bad);
      end
      checks++;
      if (iss_q[3] - iss_q[0] != 6) begin
        failures++;
        $display("FAIL stall_fetch_span: got %0d want 6", iss_q[3] - iss_q[0]);
      end
    end
    checks++;
    if (n_incoh != 0) begin
      failures++;
      $display("FAIL stall_strobes: %0d incoherent or stalled-issue cycles want 0", n_incoh);
    end
  endtask

  task automatic test_sta_wait();
    int t_done = -1;
    int r_cyc;
    cfg_num_filters = 7'd1; cfg_num_tiles = 9'd2; cfg_k_beats = 7'd2;
    sta_idle = 1'b0;
    clear_logs();
    pulse_start();
    for (int i = 0; i < 40 && t_done < 0; i++) begin
      @(posedge clk); #1;
      if (tile_done) t_done = cyc;
    end
    checks++;
    if (t_done < 0) begin
      failures++;
      $display("FAIL sta_sync: tile_done not seen within 40 cycles");
    end
    repeat (10) begin @(posedge clk); #1; end
    sta_idle = 1'b1;
    r_cyc = cyc;
    wait_done("sta_done", 300);
    checks++;
    if (sw_cyc_q.size() != 4) begin
      failures++;
      $display("FAIL sta_count: start_window=%0d want 4", sw_cyc_q.size());
    end else begin
      checks++;
      if (sw_cyc_q[1] != r_cyc + 2) begin
        failures++;
        $display("FAIL sta_release: second start_window at %0d want %0d", sw_cyc_q[1], r_cyc + 2);
      end
    end
  endtask

  task automatic test_k_zero_busy_start();
    cfg_num_filters = 7'd0; cfg_num_tiles = 9'd0; cfg_k_beats = 7'd0;
    clear_logs();
    pulse_start();
    repeat (3) begin @(posedge clk); #1; end
    pulse_start();
    @(posedge clk); #1;
    pulse_start();
    wait_done("kzero_done", 200);
    repeat (30) begin @(posedge clk); #1; end
    checks++;
    if (iss_q.size() != 2 || val_q.size() != 2 || sw_cyc_q.size() != 2) begin
      failures++;
      $display("FAIL kzero_clamp: issues=%0d valids=%0d start_window=%0d want 2/2/2",
               iss_q.size(), val_q.size(), sw_cyc_q.size());
    end
    checks++;
    if (n_ad != 1 || rsta_layer_q.size() != 2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_ignored: all_done=%0d reset_sta=%0d busy=%b want 1/2/0",
               n_ad, rsta_layer_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    cfg_num_filters = 7'd1; cfg_num_tiles = 9'd1; cfg_k_beats = 7'd4;
    clear_logs();
    pulse_start();
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (read_inputs && layer_idx) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_mid_sync: layer 1 fetch not seen within 40 cycles");
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({reset_sta, start_window, read_inputs, read_weights, incr_ptr_act,
         incr_ptr_wgt, valid_in_act, valid_in_wgt, tile_done, busy, all_done} !== 11'b0) begin
      failures++;
      $display("FAIL reset_mid_strobes: got %b want 0", {reset_sta, start_window, read_inputs,
               read_weights, incr_ptr_act, incr_ptr_wgt, valid_in_act, valid_in_wgt,
               tile_done, busy, all_done});
    end
    checks++;
    if (layer_idx !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_layer: got %b want 0", layer_idx);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    pulse_start();
    wait_done("restart_done", 200);
    checks++;
    if (rsta_layer_q.size() != 2 || n_ad != 1 || iss_q.size() != 8) begin
      failures++;
      $display("FAIL restart_run: reset_sta=%0d all_done=%0d issues=%0d want 2/1/8",
               rsta_layer_q.size(), n_ad, iss_q.size());
    end else begin
      checks++;
      if (rsta_layer_q[0] != 0) begin
        failures++;
        $display("FAIL restart_layer: got %0d want 0", rsta_layer_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nested();
    test_stall();
    test_sta_wait();
    test_k_zero_busy_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
